ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Byte-serial memory responder at the RAM end of the memory-controller interface.
- Accepts one byte access per cycle (address, read/write select, write byte) and returns read data one cycle later.
- Holds an internal byte-addressed RAM plus a small memory-mapped I/O window:
  - transmit FIFO toward a host sink
  - receive byte from host
  - halt register
- Used as the simulation/FPGA-side memory for the CPU core.

Parameters:
ADDR_WIDTH, 17, RAM address bits; RAM holds 2^ADDR_WIDTH bytes
IO_BASE, 32'h0003_0000, first I/O address; all addresses >= IO_BASE are I/O
TX_DEPTH, 8, transmit FIFO entries (power of two, >= 2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  chip enable; when 0 no access is performed and all state holds
mem_wr  input  1  1 = write, 0 = read
mem_addr  input  32  byte address; 32'hFFFF_FFFF = idle, no access
mem_din  input  8  write byte
mem_dout  output  8  read byte, registered
io_stall  output  1  tx FIFO full; upstream must withhold I/O writes
tx_data  output  8  head of tx FIFO
tx_valid  output  1  tx FIFO non-empty
tx_ready  input  1  sink accepts head when tx_valid && tx_ready
rx_data  input  8  host input byte
rx_valid  input  1  rx_data is valid
rx_ready  output  1  one-cycle pulse: rx byte consumed
halt  output  1  sticky program-end flag

Behaviour:
- Reset (async, rst_n=0):
  - mem_dout=0, tx FIFO empty (tx_valid=0, tx_data=0), rx_ready=0, halt=0.
  - RAM contents are not reset.
- Access qualifier: acc = en && mem_addr != 32'hFFFF_FFFF.
- RAM region (mem_addr < IO_BASE): index = mem_addr[ADDR_WIDTH-1:0]; higher address bits are ignored (aliasing/wrap).
  - Write: RAM[index] <= mem_din at the edge.
  - Read: mem_dout <= RAM[index] at the edge. Latency is 1 cycle: data for the address presented in cycle N is valid in cycle N+1.
- I/O map. Only IO_BASE+0 and IO_BASE+4 are decoded; other I/O addresses read 0 and ignore writes.
  - Write IO_BASE+0: push mem_din to the tx FIFO. Accepted if not full, or if a pop occurs in the same cycle. Otherwise the byte is dropped.
  - Read IO_BASE+0:
    - rx_valid=1: mem_dout <= rx_data and rx_ready pulses high for exactly that cycle.
    - rx_valid=0: mem_dout <= 0 and no pulse.
  - Write IO_BASE+4: halt <= 1 (sticky until reset), any data.
  - Read IO_BASE+4: mem_dout <= {6'b0, rx_valid, io_stall}.
- mem_dout holds its last value on cycles with no read access (idle, en=0, or write).
- rx_ready is 0 on every cycle other than the consuming read.
- tx FIFO:
  - Circular buffer with read/write pointers of log2(TX_DEPTH)+1 bits.
  - full: pointers equal except MSB. empty: pointers fully equal.
  - Pop when tx_valid && tx_ready.
  - Simultaneous push and pop:
    - when empty: push only (nothing to pop).
    - otherwise: both occur, count unchanged.
  - io_stall = full, combinational from the pointers.
  - tx_data = head entry, 0 when empty.
- en=0: no RAM write, no FIFO push, no rx consume, mem_dout holds. tx pops still proceed; the sink is independent of en.
- Reset asserted mid-stream empties the FIFO immediately; bytes in flight are lost.

Optional Feature:
- Macro: RAM_ACCESS_CNT_EN.
- Defined:
  - Adds output ports rd_cnt[31:0] and wr_cnt[31:0].
  - Each increments by 1 per accepted read/write access, RAM or I/O, including dropped tx writes.
  - Both are 0 on reset and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Write 8'hA5 to 0x00010 (en=1), then read 0x00010 -> mem_dout=8'hA5 exactly one cycle after the read address; idle cycle after -> mem_dout stays 8'hA5.
- Write 8'h3C to 0x20010 with ADDR_WIDTH=17 -> read 0x00010 returns 8'h3C (aliasing); address 32'hFFFF_FFFF with mem_wr=1 -> RAM unchanged.
- tx_ready=0, write bytes 1..9 to IO_BASE -> io_stall=1 after the 8th, 9th byte dropped; then raise tx_ready -> tx_data sequence 1..8, tx_valid falls after 8, io_stall falls after first pop.
- rx_valid=1, rx_data=8'h41, read IO_BASE -> mem_dout=8'h41 next cycle, rx_ready one-cycle pulse; with rx_valid=0 -> mem_dout=0, no pulse; read IO_BASE+4 with rx_valid=1 and FIFO full -> 8'h03.
- Write IO_BASE+4 -> halt=1 and stays; assert rst_n=0 asynchronously mid-cycle -> halt, tx_valid, mem_dout go 0 without waiting for a clock edge.
- With RAM_ACCESS_CNT_EN: 3 reads, 2 writes, 4 idle cycles, 1 cycle en=0 with a valid address -> rd_cnt=3, wr_cnt=2.

Source files
------------

// File: rtl/ram_responder.sv
// Byte-serial RAM + memory-mapped I/O responder for the CPU memory port.
// Latency: read data is registered and valid one cycle after the address; rx_ready is combinational.
// Backpressure: io_stall flags a full tx FIFO; an I/O write arriving while full (and no pop) is dropped.
// Optional access counters are enabled by defining RAM_ACCESS_CNT_EN.
module ram_responder #(
  parameter int          ADDR_WIDTH = 17,
  parameter logic [31:0] IO_BASE    = 32'h0003_0000,
  parameter int          TX_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic        io_stall,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halt
`ifdef RAM_ACCESS_CNT_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
`endif
);

  localparam int PW = $clog2(TX_DEPTH) + 1;

  logic [7:0]    ram_q [2**ADDR_WIDTH];
  logic [7:0]    fifo_q [TX_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_dout_q, mem_dout_d;
  logic          halt_q, halt_d;

  logic acc, is_io, ram_wr, rd_acc, tx_wr, halt_wr, fifo_full, fifo_empty, push, pop;
  logic [ADDR_WIDTH-1:0] idx;

  // Address decode and FIFO status
  always_comb begin
    acc        = en && (mem_addr != 32'hFFFF_FFFF);
    is_io      = mem_addr >= IO_BASE;
    idx        = mem_addr[ADDR_WIDTH-1:0];
    ram_wr     = acc && !is_io && mem_wr;
    rd_acc     = acc && !mem_wr;
    tx_wr      = acc && mem_wr && (mem_addr == IO_BASE);
    halt_wr    = acc && mem_wr && (mem_addr == IO_BASE + 32'd4);
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {(PW-1){1'b0}}});
    pop        = !fifo_empty && tx_ready;
    // A full FIFO can still accept when the head leaves in the same cycle.
    push       = tx_wr && (!fifo_full || pop);
  end

  // Next-state: pointers, halt flag and read-data mux
  always_comb begin
    wr_ptr_d   = wr_ptr_q + (push ? PW'(1) : PW'(0));
    rd_ptr_d   = rd_ptr_q + (pop ? PW'(1) : PW'(0));
    halt_d     = halt_q || halt_wr;
    mem_dout_d = mem_dout_q;
    if (rd_acc) begin
      if (!is_io) begin
        mem_dout_d = ram_q[idx];
      end else if (mem_addr == IO_BASE) begin
        mem_dout_d = rx_valid ? rx_data : 8'h00;
      end else if (mem_addr == IO_BASE + 32'd4) begin
        mem_dout_d = {6'b0, rx_valid, fifo_full};
      end else begin
        mem_dout_d = 8'h00;
      end
    end
  end

  // RAM and FIFO storage arrays are not reset
  always_ff @(posedge clk) begin
    if (ram_wr) ram_q[idx] <= mem_din;
    if (push) fifo_q[wr_ptr_q[PW-2:0]] <= mem_din;
  end

  // Control state with async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_dout_q <= 8'h00;
      halt_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_dout_q <= mem_dout_d;
      halt_q     <= halt_d;
    end
  end

  // Output drive; rx_ready is the combinational consume strobe, forced low in reset
  always_comb begin
    mem_dout = mem_dout_q;
    halt     = halt_q;
    io_stall = fifo_full;
    tx_valid = !fifo_empty;
    tx_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q[PW-2:0]];
    rx_ready = rst_n && rd_acc && (mem_addr == IO_BASE) && rx_valid;
  end

`ifdef RAM_ACCESS_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  // Count every accepted access, including tx writes that get dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_acc) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (acc && mem_wr) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  // Access counters not built in this configuration.
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Directed self-checking bench for ram_responder (default parameters).
module tb_ram_responder;
  localparam logic [31:0] IOB  = 32'h0003_0000;
  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        mem_wr = 1'b0;
  logic [31:0] mem_addr = IDLE;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic        io_stall;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        halt;
`ifdef RAM_ACCESS_CNT_EN
  logic [31:0] rd_cnt, wr_cnt;
`endif

  int errors = 0;
  int checks = 0;

  ram_responder dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .io_stall(io_stall), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .halt(halt)
`ifdef RAM_ACCESS_CNT_EN
    , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic [31:0] a, input logic [7:0] d);
    en = e; mem_wr = w; mem_addr = a; mem_din = d;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_dout", {24'b0, mem_dout}, 32'h0);
    chk("rst_txv", {31'b0, tx_valid}, 32'h0);
    chk("rst_txd", {24'b0, tx_data}, 32'h0);
    chk("rst_rxr", {31'b0, rx_ready}, 32'h0);
    chk("rst_halt", {31'b0, halt}, 32'h0);
    chk("rst_stall", {31'b0, io_stall}, 32'h0);
    #10 rst_n = 1'b1;
    tick();

`ifdef RAM_ACCESS_CNT_EN
    // Counters: 3 reads, 2 writes, 4 idle, 1 disabled access
    drive(1, 1, 32'h40, 8'h11); tick();
    drive(1, 0, 32'h40, 8'h00); tick();
    drive(1, 1, 32'h41, 8'h22); tick();
    drive(1, 0, 32'h41, 8'h00); tick();
    drive(1, 0, 32'h40, 8'h00); tick();
    drive(1, 0, IDLE, 8'h00); tick(); tick(); tick(); tick();
    drive(0, 0, 32'h40, 8'h00); tick();
    chk("rd_cnt", rd_cnt, 32'd3);
    chk("wr_cnt", wr_cnt, 32'd2);
`endif

    // RAM write then read, one-cycle latency, hold on idle
    drive(1, 1, 32'h10, 8'hA5); tick();
    chk("wr_no_dout", {24'b0, mem_dout}, {24'b0, 8'h00});
    drive(1, 0, 32'h10, 8'h00); tick();
    chk("rd_a5", {24'b0, mem_dout}, 32'hA5);
    drive(1, 0, IDLE, 8'h00); tick();
    chk("idle_hold", {24'b0, mem_dout}, 32'hA5);

    // Aliasing above ADDR_WIDTH bits, idle write, disabled write
    drive(1, 1, 32'h20010, 8'h3C); tick();
    drive(1, 1, IDLE, 8'h77); tick();
    drive(0, 1, 32'h10, 8'h99); tick();
    drive(0, 0, 32'h11, 8'h00); tick();
    chk("en0_hold", {24'b0, mem_dout}, 32'hA5);
    drive(1, 0, 32'h10, 8'h00); tick();
    chk("alias_3c", {24'b0, mem_dout}, 32'h3C);

    // Fill tx FIFO with 1..9 while sink stalls
    tx_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      drive(1, 1, IOB, 8'(k)); tick();
      if (k == 7) chk("stall_lo7", {31'b0, io_stall}, 32'h0);
      if (k == 8) chk("stall_hi8", {31'b0, io_stall}, 32'h1);
    end
    chk("txd_head", {24'b0, tx_data}, 32'h1);
    rx_valid = 1'b1; rx_data = 8'h5A;
    drive(1, 0, IOB + 32'd4, 8'h00);
    #1 chk("status_noready", {31'b0, rx_ready}, 32'h0);
    tick();
    chk("status_03", {24'b0, mem_dout}, 32'h03);
    rx_valid = 1'b0;
    drive(1, 0, IDLE, 8'h00);
    tx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("tx_seq%0d", k), {24'b0, tx_data}, 32'(k));
      tick();
      if (k == 1) chk("stall_fall", {31'b0, io_stall}, 32'h0);
    end
    chk("txv_empty", {31'b0, tx_valid}, 32'h0);
    chk("txd_empty", {24'b0, tx_data}, 32'h0);
    tx_ready = 1'b0;

    // rx consume, unmapped I/O, rx empty
    rx_valid = 1'b1; rx_data = 8'h41;
    drive(1, 0, IOB, 8'h00);
    #1 chk("rxr_pulse", {31'b0, rx_ready}, 32'h1);
    tick();
    chk("rx_41", {24'b0, mem_dout}, 32'h41);
    drive(1, 0, IDLE, 8'h00);
    #1 chk("rxr_low", {31'b0, rx_ready}, 32'h0);
    drive(1, 0, IOB + 32'd8, 8'h00); tick();
    chk("io_unmapped", {24'b0, mem_dout}, 32'h0);
    drive(1, 0, 32'h10, 8'h00); tick();
    rx_valid = 1'b0;
    drive(1, 0, IOB, 8'h00);
    #1 chk("rxr_nopulse", {31'b0, rx_ready}, 32'h0);
    tick();
    chk("rx_empty0", {24'b0, mem_dout}, 32'h0);

    // Halt sticky, then async reset mid-cycle
    drive(1, 1, IOB + 32'd4, 8'h00); tick();
    chk("halt_set", {31'b0, halt}, 32'h1);
    drive(1, 1, IOB, 8'h55); tick();
    drive(1, 0, 32'h10, 8'h00); tick();
    drive(1, 0, IDLE, 8'h00); tick();
    chk("halt_sticky", {31'b0, halt}, 32'h1);
    chk("pre_rst_txv", {31'b0, tx_valid}, 32'h1);
    chk("pre_rst_dout", {24'b0, mem_dout}, 32'h3C);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_halt", {31'b0, halt}, 32'h0);
    chk("arst_txv", {31'b0, tx_valid}, 32'h0);
    chk("arst_dout", {24'b0, mem_dout}, 32'h0);
    #10 rst_n = 1'b1;
    tick();
    drive(1, 0, 32'h10, 8'h00); tick();
    chk("ram_kept", {24'b0, mem_dout}, 32'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
